// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) arithmetic, column width and the InvMixColumns FSM states.
package aes_pkg;

  localparam int         COL_W  = 32;
  localparam logic [7:0] GF_RED = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } imc_state_t;

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_RED : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = gf_xtime(sh);
    end
    return acc;
  endfunction

endpackage

// File: rtl/inv_mix_col32.sv
// Combinational InvMixColumns of one 32-bit column (row 0 in the MSB byte).
module inv_mix_col32
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_i,
  output logic [COL_W-1:0] col_o
);

  logic [7:0] s  [4];
  logic [7:0] x2 [4];
  logic [7:0] x4 [4];
  logic [7:0] x8 [4];
  logic [7:0] m9 [4];
  logic [7:0] mb [4];
  logic [7:0] md [4];
  logic [7:0] me [4];

  // Each coefficient is a sum of doublings of the byte, so only three xtimes per byte are needed.
  for (genvar r = 0; r < 4; r++) begin : g_byte
    assign s[r]  = col_i[COL_W-1-8*r -: 8];
    assign x2[r] = gf_xtime(s[r]);
    assign x4[r] = gf_xtime(x2[r]);
    assign x8[r] = gf_xtime(x4[r]);
    assign m9[r] = x8[r] ^ s[r];
    assign mb[r] = x8[r] ^ x2[r] ^ s[r];
    assign md[r] = x8[r] ^ x4[r] ^ s[r];
    assign me[r] = x8[r] ^ x4[r] ^ x2[r];
  end

  for (genvar r = 0; r < 4; r++) begin : g_row
    assign col_o[COL_W-1-8*r -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
  end

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Iterative InvMixColumns: one column per clock through a shared column multiplier,
// valid/ready on both sides, result driven straight from the working register.
module inv_mix_columns_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  imc_state_t        state_q, state_d;
  logic [1:0]        col_q, col_d;
  logic [127:0]      work_q, work_d;
  logic [COL_W-1:0]  col_in;
  logic [COL_W-1:0]  col_out;
  logic              accept;

  assign out_valid = (state_q == DONE);
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_data  = work_q;

  always_comb begin
    col_in = work_q[127:96];
    case (col_q)
      2'd0:    col_in = work_q[127:96];
      2'd1:    col_in = work_q[95:64];
      2'd2:    col_in = work_q[63:32];
      default: col_in = work_q[31:0];
    endcase
  end

  inv_mix_col32 u_col (
    .col_i (col_in),
    .col_o (col_out)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    work_d  = work_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          col_d   = 2'd0;
          work_d  = in_data;
        end
      end
      BUSY: begin
        case (col_q)
          2'd0:    work_d[127:96] = col_out;
          2'd1:    work_d[95:64]  = col_out;
          2'd2:    work_d[63:32]  = col_out;
          default: work_d[31:0]   = col_out;
        endcase
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        // Draining and accepting share one edge so a stream runs at one state per 5 cycles.
        if (out_ready) begin
          if (in_valid) begin
            state_d = BUSY;
            col_d   = 2'd0;
            work_d  = in_data;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      work_q  <= work_d;
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Bench for inv_mix_columns_iter: cycle-level behavioural model plus directed and random traffic.
module tb_inv_mix_columns_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;

  inv_mix_columns_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // Reference arithmetic: schoolbook polynomial product then reduction by 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] mat_apply(input logic [127:0] s, input logic [31:0] row0);
    logic [127:0] res;
    logic [7:0]   k [4];
    logic [7:0]   acc;
    for (int j = 0; j < 4; j++) k[j] = row0[31-8*j -: 8];
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(k[j], s[127-32*c-8*((r+j)%4) -: 8]);
        res[127-32*c-8*r -: 8] = acc;
      end
    return res;
  endfunction

  function automatic logic [127:0] inv_mix_ref(input logic [127:0] s);
    return mat_apply(s, 32'h0e0b0d09);
  endfunction

  function automatic logic [127:0] mix_ref(input logic [127:0] s);
    return mat_apply(s, 32'h02030101);
  endfunction

  function automatic logic [127:0] rep(input logic [31:0] c);
    return {c, c, c, c};
  endfunction

  // Model: phase 0 idle, 1..4 = compute edges pending, 5 = result held.
  int           phase = 0;
  logic [127:0] m_res = '0;
  bit           m_zero = 1'b1;
  int           cyc = 0;
  int           n_acc = 0;
  int           n_drain = 0;
  logic [127:0] last_drain = '0;
  int           drain_cyc [$];
  logic [127:0] drain_dat [$];

  always @(posedge clk) begin
    int nxt;
    bit rdy;
    cyc++;
    if (rst_n) begin
      rdy = (phase == 0) || (phase == 5 && out_ready);
      nxt = phase;
      if (phase >= 1 && phase <= 4) nxt = phase + 1;
      if (phase == 5 && out_ready) begin
        nxt = 0;
        n_drain++;
        last_drain = out_data;
        drain_cyc.push_back(cyc);
        drain_dat.push_back(out_data);
      end
      if (in_valid && rdy) begin
        nxt    = 1;
        m_res  = inv_mix_ref(in_data);
        m_zero = 1'b0;
        n_acc++;
      end
      phase = nxt;
    end
  end

  always @(negedge rst_n) begin
    phase  = 0;
    m_zero = 1'b1;
  end

  always @(negedge clk) begin
    chk1("out_valid", out_valid, phase == 5);
    chk1("in_ready", in_ready, (phase == 0) || (phase == 5 && out_ready));
    if (phase == 5) chk("out_data_hold", out_data, m_res);
    if (m_zero) chk("out_data_zero", out_data, 128'h0);
  end

  task automatic send(input logic [127:0] d);
    int base;
    base     = n_acc;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 60 && n_acc == base; i++) begin
      @(posedge clk); #2;
    end
    chk1("send_accept", n_acc != base, 1'b1);
  endtask

  task automatic recv(input string name, input logic [127:0] exp);
    int base;
    base      = n_drain;
    out_ready = 1'b1;
    for (int i = 0; i < 60 && n_drain == base; i++) begin
      @(posedge clk); #2;
    end
    chk1("recv_done", n_drain != base, 1'b1);
    chk(name, last_drain, exp);
  endtask

  logic [31:0]  vin  [6] = '{32'h8e4da1bc, 32'h9fdc589d, 32'h4d7ebdf8,
                             32'hd5d5d7d6, 32'hc6c6c6c6, 32'h01010101};
  logic [31:0]  vout [6] = '{32'hdb135345, 32'hf20a225c, 32'h2d26314c,
                             32'hd4d4d4d5, 32'hc6c6c6c6, 32'h01010101};
  logic [127:0] mixed_in  = 128'h8e4da1bc_9fdc589d_4d7ebdf8_d5d5d7d6;
  logic [127:0] mixed_out = 128'hdb135345_f20a225c_2d26314c_d4d4d4d5;
  logic [127:0] xs [8];
  logic [127:0] a_st, b_st;
  int           base_acc, base_dr;

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk1("reset_in_ready", in_ready, 1'b1);
    chk1("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_data", out_data, 128'h0);
    rst_n = 1'b1;
    @(posedge clk); #2;

    for (int i = 0; i < 6; i++) chk("model_vec", inv_mix_ref(rep(vin[i])), rep(vout[i]));
    chk("model_mixed", inv_mix_ref(mixed_in), mixed_out);
    chk("model_roundtrip", inv_mix_ref(mix_ref(128'h00112233_44556677_8899aabb_ccddeeff)),
        128'h00112233_44556677_8899aabb_ccddeeff);

    for (int i = 0; i < 6; i++) begin
      send(rep(vin[i]));
      in_valid = 1'b0;
      recv("vector", rep(vout[i]));
    end

    send(mixed_in);
    in_valid = 1'b0;
    recv("mixed", mixed_out);

    // Backpressure with a second state waiting at the input.
    a_st = {$urandom, $urandom, $urandom, $urandom};
    b_st = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b0;
    send(a_st);
    in_data = b_st;
    for (int i = 0; i < 20 && phase != 5; i++) begin
      @(posedge clk); #2;
    end
    base_acc = n_acc;
    repeat (10) begin
      @(posedge clk); #2;
    end
    chk1("bp_no_accept", n_acc == base_acc, 1'b1);
    chk("bp_hold", out_data, inv_mix_ref(a_st));
    base_dr = n_drain;
    out_ready = 1'b1;
    @(posedge clk); #2;
    chk1("bp_release_same_edge", (n_acc == base_acc + 1) && (n_drain == base_dr + 1), 1'b1);
    chk("bp_first", last_drain, inv_mix_ref(a_st));
    in_valid = 1'b0;
    recv("bp_second", inv_mix_ref(b_st));

    // Back-to-back: feed MixColumns(x), expect x back, one result per 5 cycles.
    drain_cyc.delete();
    drain_dat.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      xs[i] = {$urandom, $urandom, $urandom, $urandom};
      send(mix_ref(xs[i]));
    end
    in_valid = 1'b0;
    for (int i = 0; i < 100 && drain_cyc.size() < 8; i++) begin
      @(posedge clk); #2;
    end
    chk1("b2b_count", drain_cyc.size() == 8, 1'b1);
    if (drain_cyc.size() == 8) begin
      for (int i = 0; i < 8; i++) chk("b2b_data", drain_dat[i], xs[i]);
      for (int i = 1; i < 8; i++) chk1("b2b_interval", drain_cyc[i] - drain_cyc[i-1] == 5, 1'b1);
    end

    // Abort after two compute edges.
    send(rep(vin[0]));
    in_valid = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk1("abort_out_valid", out_valid, 1'b0);
    chk1("abort_in_ready", in_ready, 1'b1);
    chk("abort_out_data", out_data, 128'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #2;
    end
    send(rep(vin[2]));
    in_valid = 1'b0;
    recv("after_abort", rep(vout[2]));

    // All-zero state with stray in_valid while busy.
    send(128'h0);
    in_data = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) begin
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    recv("zero", 128'h0);

    repeat (3) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
